// File: rtl/ifetch_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch stage.
package ifetch_pkg;

  localparam int              DEF_ADDR_W   = 8;
  localparam int              DEF_INSTR_W  = 16;
  localparam logic [7:0]      DEF_RESET_PC = 8'h00;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} pairs; head is read straight from the
// registered storage and forced to zero while empty.
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_reg[wr_ptr_reg] <= wdata;
  end

  assign head  = empty ? '0 : mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT control and redirect handling
// in front of a small fetch FIFO feeding decode.
module ifetch_stage
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   pc_reg;
  logic [ADDR_W-1:0]   pc_next;
  logic                pop;
  logic                push;
  logic [ENT_W-1:0]    fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  assign pop  = if_valid && id_ready;
  // Redirect wins: nothing fetched from the stale path is kept.
  assign push = (state_reg == S_RUN) && !redirect_valid && (!fifo_full || pop);

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid)
      pc_next = redirect_pc;
    else if (push)
      pc_next = pc_reg + ADDR_W'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RUN:   if (halt_req) state_next = S_HALT;
      S_HALT:  if (redirect_valid && !halt_req) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_RUN;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc_reg, rom_data}),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rom_addr = pc_reg;
  assign if_valid = (fifo_count != '0);
  assign if_pc    = fifo_head[INSTR_W +: ADDR_W];
  assign if_instr = fifo_head[INSTR_W-1:0];
  assign halted   = (state_reg == S_HALT) && fifo_empty;

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed scenarios plus random traffic checked
// against a queue-based model of the fetch stage.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt_req;
  logic        halted;

  int tests_run  = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  logic [15:0] prog [8] = '{16'hC000, 16'hC801, 16'hD002, 16'hD803,
                            16'hE004, 16'hE805, 16'hF006, 16'hF807};

  assign rom_data = rom[rom_addr];

  ifetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  // Reference model: the FIFO is a queue of fetched pairs, halting is a flag.
  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } ent_t;

  ent_t       q[$];
  logic [7:0] m_pc;
  bit         m_halt;

  function automatic logic e_valid();
    return q.size() != 0;
  endfunction

  function automatic logic [7:0] e_pc();
    return (q.size() != 0) ? q[0].pc : 8'h00;
  endfunction

  function automatic logic [15:0] e_instr();
    return (q.size() != 0) ? q[0].instr : 16'h0000;
  endfunction

  function automatic logic e_halted();
    return m_halt && (q.size() == 0);
  endfunction

  task automatic tick();
    bit pop_now;
    bit push_now;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_pc   = 8'h00;
      m_halt = 1'b0;
    end else begin
      pop_now = (q.size() != 0) && id_ready;
      if (redirect_valid) begin
        q.delete();
        m_pc   = redirect_pc;
        m_halt = halt_req;
      end else begin
        push_now = !m_halt && ((q.size() < 2) || pop_now);
        if (pop_now) void'(q.pop_front());
        if (push_now) begin
          q.push_back('{pc: m_pc, instr: rom[m_pc]});
          m_pc = m_pc + 8'd1;
        end
        if (halt_req) m_halt = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    id_ready = 1'b1;
    redirect_pc = 8'h00;
    do_reset(2);
    tests_run++;
    if (if_valid !== 1'b0 || if_pc !== 8'h00 || if_instr !== 16'h0000 ||
        halted !== 1'b0 || rom_addr !== 8'h00) begin
      fail_count++;
      $display("FAIL reset: got valid=%b pc=%h instr=%h halted=%b addr=%h, want 0/00/0000/0/00",
               if_valid, if_pc, if_instr, halted, rom_addr);
    end
  endtask

  task automatic test_stream();
    id_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 8'(i) || if_instr !== prog[i]) begin
        fail_count++;
        $display("FAIL stream[%0d]: got valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, if_valid, if_pc, if_instr, 8'(i), prog[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(2);
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 16'hC000) begin
        fail_count++;
        $display("FAIL backpressure hold[%0d]: got valid=%b pc=%h instr=%h, want 1/00/C000",
                 i, if_valid, if_pc, if_instr);
      end
    end
    tests_run++;
    if (rom_addr !== 8'h02) begin
      fail_count++;
      $display("FAIL backpressure pc: got %h, want 02", rom_addr);
    end
    id_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== 8'(k) || if_instr !== prog[k]) begin
        fail_count++;
        $display("FAIL backpressure drain[%0d]: got valid=%b pc=%h instr=%h, want 1/%h/%h",
                 k, if_valid, if_pc, if_instr, 8'(k), prog[k]);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    int n = 0;
    id_ready = 1'b1;
    while (if_pc !== 8'h0F && n < 64) begin
      tick();
      n++;
    end
    tests_run++;
    if (if_pc !== 8'h0F || if_instr !== 16'h9000) begin
      fail_count++;
      $display("FAIL redirect reach BRN: got pc=%h instr=%h, want 0F/9000", if_pc, if_instr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL redirect bubble: got valid=%b, want 0", if_valid);
    end
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 16'hC000) begin
      fail_count++;
      $display("FAIL redirect target: got valid=%b pc=%h instr=%h, want 1/00/C000",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  wpc [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [15:0] wins[4] = '{16'h0000, 16'h0000, 16'hC000, 16'hC801};
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    tick();
    redirect_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (if_valid !== 1'b1 || if_pc !== wpc[i] || if_instr !== wins[i]) begin
        fail_count++;
        $display("FAIL wrap[%0d]: got valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, if_valid, if_pc, if_instr, wpc[i], wins[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    int pops = 0;
    int n = 0;
    logic [7:0] frozen;
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    id_ready = 1'b1;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    while (!halted && n < 10) begin
      if (if_valid && id_ready) pops++;
      tick();
      n++;
    end
    tests_run++;
    if (pops != 2 || halted !== 1'b1) begin
      fail_count++;
      $display("FAIL halt drain: got pops=%0d halted=%b, want 2/1", pops, halted);
    end
    frozen = rom_addr;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (rom_addr !== frozen || halted !== 1'b1 || if_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL halt freeze: got addr=%h halted=%b valid=%b, want %h/1/0",
               rom_addr, halted, if_valid, frozen);
    end
    redirect_valid = 1'b1;
    redirect_pc = 8'h05;
    tick();
    redirect_valid = 1'b0;
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h05 || if_instr !== 16'hE805 || halted !== 1'b0) begin
      fail_count++;
      $display("FAIL halt resume: got valid=%b pc=%h instr=%h halted=%b, want 1/05/E805/0",
               if_valid, if_pc, if_instr, halted);
    end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    do_reset(1);
    tests_run++;
    if (if_valid !== 1'b0 || rom_addr !== 8'h00) begin
      fail_count++;
      $display("FAIL reset_mid clear: got valid=%b addr=%h, want 0/00", if_valid, rom_addr);
    end
    id_ready = 1'b1;
    tick();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 8'h00 || if_instr !== 16'hC000) begin
      fail_count++;
      $display("FAIL reset_mid restart: got valid=%b pc=%h instr=%h, want 1/00/C000",
               if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n          = ($urandom_range(0, 63) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255))
                                                   : 8'($urandom_range(0, 15));
      halt_req       = ($urandom_range(0, 15) == 0);
      tests_run++;
      if (if_valid !== e_valid() || if_pc !== e_pc() || if_instr !== e_instr() ||
          halted !== e_halted() || rom_addr !== m_pc) begin
        fail_count++;
        $display("FAIL random[%0d]: got v=%b pc=%h instr=%h halted=%b addr=%h, want v=%b pc=%h instr=%h halted=%b addr=%h",
                 c, if_valid, if_pc, if_instr, halted, rom_addr,
                 e_valid(), e_pc(), e_instr(), e_halted(), m_pc);
      end
      tick();
    end
    rst_n = 1'b1;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rom[i] = prog[i];
    for (int i = 8; i < 15; i++) rom[i] = 16'hA000 + 16'(i);
    rom[15] = 16'h9000;
    rst_n = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    halt_req = 1'b0;
    m_pc = 8'h00;
    m_halt = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
